// File: rtl/magic_grid_loader.sv
// ---------------------------------------------------------------------------
// magic_grid_loader
//
// Upstream stage of the 3x3 magic-square checker. Digits arrive one at a
// time over a valid/ready handshake. They fill cells num1..num9 in row-major
// order. Once the ninth cell is written, the grid is held for one CHECK cycle
// while the external combinational checker evaluates it. Its verdict is then
// registered and held in DONE until the consumer acknowledges it.
//
// Optional feature: define MAGIC_LOADER_DUP_CHECK_EN to reject in-range
// digits that are already present in the grid. With this feature enabled,
// a completed grid is always a permutation of DIGIT_MIN..DIGIT_MAX.
//
// Ports:
//   clock               system clock, rising edge
//   reset_L             asynchronous active-low reset
//   in_valid/in_digit   offered digit
//   in_ready            loader accepts a digit this cycle (combinational)
//   clear               synchronous abort, restarts loading
//   ack                 consumer has read the verdict (only honoured in DONE)
//   num1..num9          grid cells, driven to the checker
//   chk_is_magic        checker verdict for the current grid
//   chk_magic_constant  checker magic constant for the current grid
//   count               number of filled cells, 0..9
//   bad_digit           one-cycle pulse after a rejected digit
//   done                registered verdict is valid
//   result_magic        registered verdict
//   result_constant     registered magic constant
// ---------------------------------------------------------------------------
module magic_grid_loader #(
  parameter int DIGIT_MIN = 1,
  parameter int DIGIT_MAX = 9
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       in_valid,
  input  logic [3:0] in_digit,
  output logic       in_ready,
  input  logic       clear,
  input  logic       ack,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [3:0] num5,
  output logic [3:0] num6,
  output logic [3:0] num7,
  output logic [3:0] num8,
  output logic [3:0] num9,
  input  logic       chk_is_magic,
  input  logic [7:0] chk_magic_constant,
  output logic [3:0] count,
  output logic       bad_digit,
  output logic       done,
  output logic       result_magic,
  output logic [7:0] result_constant
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MIN_V = 4'(DIGIT_MIN);
  localparam logic [3:0] DIGIT_MAX_V = 4'(DIGIT_MAX);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] cells_q [9];
  logic [3:0] cells_d [9];
  logic       bad_digit_q, bad_digit_d;
  logic       done_q, done_d;
  logic       result_magic_q, result_magic_d;
  logic [7:0] result_constant_q, result_constant_d;

  logic digit_in_range;
  logic digit_ok;

  assign digit_in_range = (in_digit >= DIGIT_MIN_V) && (in_digit <= DIGIT_MAX_V);

`ifdef MAGIC_LOADER_DUP_CHECK_EN
  // One bit per legal digit value; set when that value is written to the grid.
  logic [8:0] seen_q, seen_d;
  logic [3:0] seen_idx;

  assign seen_idx = in_digit - DIGIT_MIN_V;
  assign digit_ok = digit_in_range && !seen_q[seen_idx];
`else
  assign digit_ok = digit_in_range;
`endif

  // clear blocks the handshake so that a digit offered with it is dropped.
  assign in_ready = (state_q == LOAD) && !clear;

  always_comb begin
    state_d           = state_q;
    count_d           = count_q;
    cells_d           = cells_q;
    bad_digit_d       = 1'b0;
    done_d            = done_q;
    result_magic_d    = result_magic_q;
    result_constant_d = result_constant_q;
`ifdef MAGIC_LOADER_DUP_CHECK_EN
    seen_d            = seen_q;
`endif

    if (clear) begin
      state_d = LOAD;
      count_d = '0;
      done_d  = 1'b0;
      for (int i = 0; i < 9; i++) cells_d[i] = '0;
`ifdef MAGIC_LOADER_DUP_CHECK_EN
      seen_d  = '0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            if (digit_ok) begin
              cells_d[count_q] = in_digit;
              count_d          = count_q + 4'd1;
`ifdef MAGIC_LOADER_DUP_CHECK_EN
              seen_d[seen_idx] = 1'b1;
`endif
              if (count_q == 4'd8) state_d = CHECK;
            end else begin
              bad_digit_d = 1'b1;
            end
          end
        end
        // The grid has been stable since the last write, so the checker's
        // combinational verdict is settled and can be sampled here.
        CHECK: begin
          result_magic_d    = chk_is_magic;
          result_constant_d = chk_magic_constant;
          done_d            = 1'b1;
          state_d           = DONE;
        end
        DONE: begin
          if (ack) begin
            state_d = LOAD;
            count_d = '0;
            done_d  = 1'b0;
            for (int i = 0; i < 9; i++) cells_d[i] = '0;
`ifdef MAGIC_LOADER_DUP_CHECK_EN
            seen_d  = '0;
`endif
          end
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q           <= LOAD;
      count_q           <= '0;
      for (int i = 0; i < 9; i++) cells_q[i] <= '0;
      bad_digit_q       <= 1'b0;
      done_q            <= 1'b0;
      result_magic_q    <= 1'b0;
      result_constant_q <= '0;
`ifdef MAGIC_LOADER_DUP_CHECK_EN
      seen_q            <= '0;
`endif
    end else begin
      state_q           <= state_d;
      count_q           <= count_d;
      cells_q           <= cells_d;
      bad_digit_q       <= bad_digit_d;
      done_q            <= done_d;
      result_magic_q    <= result_magic_d;
      result_constant_q <= result_constant_d;
`ifdef MAGIC_LOADER_DUP_CHECK_EN
      seen_q            <= seen_d;
`endif
    end
  end

  assign num1            = cells_q[0];
  assign num2            = cells_q[1];
  assign num3            = cells_q[2];
  assign num4            = cells_q[3];
  assign num5            = cells_q[4];
  assign num6            = cells_q[5];
  assign num7            = cells_q[6];
  assign num8            = cells_q[7];
  assign num9            = cells_q[8];
  assign count           = count_q;
  assign bad_digit       = bad_digit_q;
  assign done            = done_q;
  assign result_magic    = result_magic_q;
  assign result_constant = result_constant_q;

endmodule

// File: tb/tb_magic_grid_loader.sv
// ---------------------------------------------------------------------------
// tb_magic_grid_loader
//
// This testbench drives directed digit sequences into magic_grid_loader.
// It includes a small model of the combinational checker:
//   - the magic constant is the sum of the first row;
//   - the grid is magic when all eight lines add up to that constant.
// When the testbench issues the ninth digit of a grid, it pushes the
// expected verdict into a queue. A monitor pops that entry on each rising
// edge of done and compares it with the registered verdict.
// ---------------------------------------------------------------------------
module tb_magic_grid_loader;

  logic       clock;
  logic       reset_L;
  logic       in_valid;
  logic [3:0] in_digit;
  logic       in_ready;
  logic       clear;
  logic       ack;
  logic [3:0] num1, num2, num3, num4, num5, num6, num7, num8, num9;
  logic       chk_is_magic;
  logic [7:0] chk_magic_constant;
  logic [3:0] count;
  logic       bad_digit;
  logic       done;
  logic       result_magic;
  logic [7:0] result_constant;

  typedef struct {
    logic       magic;
    logic [7:0] constant;
    logic [3:0] n1;
    logic [3:0] n9;
  } verdict_t;

  verdict_t expQ[$];

  int vectors    = 0;
  int miscompares = 0;
  logic doneSeen = 1'b0;

  magic_grid_loader dut (
    .clock              (clock),
    .reset_L            (reset_L),
    .in_valid           (in_valid),
    .in_digit           (in_digit),
    .in_ready           (in_ready),
    .clear              (clear),
    .ack                (ack),
    .num1               (num1),
    .num2               (num2),
    .num3               (num3),
    .num4               (num4),
    .num5               (num5),
    .num6               (num6),
    .num7               (num7),
    .num8               (num8),
    .num9               (num9),
    .chk_is_magic       (chk_is_magic),
    .chk_magic_constant (chk_magic_constant),
    .count              (count),
    .bad_digit          (bad_digit),
    .done               (done),
    .result_magic       (result_magic),
    .result_constant    (result_constant)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Checker model: first-row sum is reported as the constant.
  always_comb begin
    logic [7:0] r1, r2, r3, c1, c2, c3, d1, d2;
    r1 = 8'(num1) + 8'(num2) + 8'(num3);
    r2 = 8'(num4) + 8'(num5) + 8'(num6);
    r3 = 8'(num7) + 8'(num8) + 8'(num9);
    c1 = 8'(num1) + 8'(num4) + 8'(num7);
    c2 = 8'(num2) + 8'(num5) + 8'(num8);
    c3 = 8'(num3) + 8'(num6) + 8'(num9);
    d1 = 8'(num1) + 8'(num5) + 8'(num9);
    d2 = 8'(num3) + 8'(num5) + 8'(num7);
    chk_magic_constant = r1;
    chk_is_magic = (r2 == r1) && (r3 == r1) && (c1 == r1) && (c2 == r1) &&
                   (c3 == r1) && (d1 == r1) && (d2 == r1);
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock of stimulus. Outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [3:0] d,
                               input logic clr, input logic ak);
    in_valid = v;
    in_digit = d;
    clear    = clr;
    ack      = ak;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_digit = 4'd0;
    clear    = 1'b0;
    ack      = 1'b0;
  endtask

  // Issue nine digits back to back.
  // If the grid is expected to reach the checker, queue the verdict
  // just before the ninth digit is accepted.
  task automatic loadGrid(input logic [3:0] g [9], input logic expectVerdict,
                          input logic magic, input logic [7:0] constant);
    verdict_t v;
    for (int i = 0; i < 9; i++) begin
      if (i == 8 && expectVerdict) begin
        v.magic    = magic;
        v.constant = constant;
        v.n1       = g[0];
        v.n9       = g[8];
        expQ.push_back(v);
      end
      applyStimulus(1'b1, g[i], 1'b0, 1'b0);
    end
  endtask

  // Scoreboard monitor: compare the queued verdict on each rising edge of done.
  always @(negedge clock) begin
    if (reset_L && done && !doneSeen) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_verdict: got done=1, expected no verdict");
      end else begin
        verdict_t e;
        e = expQ.pop_front();
        checkOutput("sb_result_magic", {7'd0, result_magic}, {7'd0, e.magic});
        checkOutput("sb_result_constant", result_constant, e.constant);
        checkOutput("sb_num1", {4'd0, num1}, {4'd0, e.n1});
        checkOutput("sb_num9", {4'd0, num9}, {4'd0, e.n9});
      end
    end
    doneSeen = done;
  end

  initial begin
    logic [3:0] gMagic [9];
    logic [3:0] gSeq   [9];
    logic [3:0] gFives [9];
    gMagic = '{4'd2, 4'd7, 4'd6, 4'd9, 4'd5, 4'd1, 4'd4, 4'd3, 4'd8};
    gSeq   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    gFives = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};

    reset_L  = 1'b0;
    in_valid = 1'b0;
    in_digit = 4'd0;
    clear    = 1'b0;
    ack      = 1'b0;
    #12;
    checkOutput("rst_count", {4'd0, count}, 8'd0);
    checkOutput("rst_done", {7'd0, done}, 8'd0);
    checkOutput("rst_bad_digit", {7'd0, bad_digit}, 8'd0);
    checkOutput("rst_result_magic", {7'd0, result_magic}, 8'd0);
    checkOutput("rst_result_constant", result_constant, 8'd0);
    checkOutput("rst_num5", {4'd0, num5}, 8'd0);
    checkOutput("rst_in_ready", {7'd0, in_ready}, 8'd1);
    reset_L = 1'b1;
    @(negedge clock);

    // Lo Shu square: verdict appears one cycle after the ninth digit.
    $display("[TB] magic grid 2,7,6,9,5,1,4,3,8");
    loadGrid(gMagic, 1'b1, 1'b1, 8'd15);
    checkOutput("t1_count9", {4'd0, count}, 8'd9);
    checkOutput("t1_done_not_yet", {7'd0, done}, 8'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t1_done", {7'd0, done}, 8'd1);

    // Digits offered in DONE are ignored and do not raise bad_digit.
    in_valid = 1'b1;
    in_digit = 4'd6;
    #1;
    checkOutput("t6_in_ready_done", {7'd0, in_ready}, 8'd0);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
    checkOutput("t6_count", {4'd0, count}, 8'd9);
    checkOutput("t6_num1", {4'd0, num1}, 8'd2);
    checkOutput("t6_bad_digit", {7'd0, bad_digit}, 8'd0);
    checkOutput("t6_result_magic", {7'd0, result_magic}, 8'd1);
    checkOutput("t6_done_held", {7'd0, done}, 8'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("t1_ack_done", {7'd0, done}, 8'd0);
    checkOutput("t1_ack_result_kept", result_constant, 8'd15);

    // Sequential grid: not magic, first-row sum 6.
    $display("[TB] grid 1..9 then ack");
    loadGrid(gSeq, 1'b1, 1'b0, 8'd6);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t2_done", {7'd0, done}, 8'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("t2_ack_done", {7'd0, done}, 8'd0);
    checkOutput("t2_ack_count", {4'd0, count}, 8'd0);
    checkOutput("t2_ack_num1", {4'd0, num1}, 8'd0);
    checkOutput("t2_ack_num9", {4'd0, num9}, 8'd0);
    checkOutput("t2_ack_in_ready", {7'd0, in_ready}, 8'd1);
    checkOutput("t2_result_kept", result_constant, 8'd6);

    // Out-of-range digits are rejected at count 3.
    $display("[TB] reject 0 and 11 at count 3");
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
    checkOutput("t3_bad_idle", {7'd0, bad_digit}, 8'd0);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("t3_bad0", {7'd0, bad_digit}, 8'd1);
    checkOutput("t3_count_a", {4'd0, count}, 8'd3);
    applyStimulus(1'b1, 4'd11, 1'b0, 1'b0);
    checkOutput("t3_bad11", {7'd0, bad_digit}, 8'd1);
    checkOutput("t3_count_b", {4'd0, count}, 8'd3);
    checkOutput("t3_num4_empty", {4'd0, num4}, 8'd0);
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
    checkOutput("t3_num4", {4'd0, num4}, 8'd9);
    checkOutput("t3_count4", {4'd0, count}, 8'd4);
    checkOutput("t3_bad_cleared", {7'd0, bad_digit}, 8'd0);

    // clear at count 5 drops the simultaneous digit.
    $display("[TB] clear at count 5");
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    checkOutput("t4_count5", {4'd0, count}, 8'd5);
    in_valid = 1'b1;
    in_digit = 4'd4;
    clear    = 1'b1;
    #1;
    checkOutput("t4_in_ready_clear", {7'd0, in_ready}, 8'd0);
    applyStimulus(1'b1, 4'd4, 1'b1, 1'b0);
    checkOutput("t4_count0", {4'd0, count}, 8'd0);
    checkOutput("t4_num1", {4'd0, num1}, 8'd0);
    checkOutput("t4_num4", {4'd0, num4}, 8'd0);
    checkOutput("t4_num6", {4'd0, num6}, 8'd0);

    // All fives.
`ifdef MAGIC_LOADER_DUP_CHECK_EN
    $display("[TB] all fives with duplicate rejection");
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    checkOutput("t5_dup_bad", {7'd0, bad_digit}, 8'd1);
    checkOutput("t5_dup_count", {4'd0, count}, 8'd1);
    checkOutput("t5_dup_num2", {4'd0, num2}, 8'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("t5_clear_count", {4'd0, count}, 8'd0);
`else
    $display("[TB] all fives without duplicate rejection");
    loadGrid(gFives, 1'b1, 1'b1, 8'd15);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t5_done", {7'd0, done}, 8'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("t5_ack_count", {4'd0, count}, 8'd0);
`endif

    // Reset in CHECK: no verdict is registered.
    $display("[TB] reset during CHECK");
    loadGrid(gMagic, 1'b0, 1'b0, 8'd0);
    checkOutput("t7_in_check_count", {4'd0, count}, 8'd9);
    reset_L = 1'b0;
    #1;
    checkOutput("t7_rst_done", {7'd0, done}, 8'd0);
    checkOutput("t7_rst_result_magic", {7'd0, result_magic}, 8'd0);
    checkOutput("t7_rst_count", {4'd0, count}, 8'd0);
    #1;
    reset_L = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t7_no_verdict", {7'd0, done}, 8'd0);
    checkOutput("t7_in_ready", {7'd0, in_ready}, 8'd1);

    checkOutput("sb_queue_empty", 8'(expQ.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
